// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the serial ALU: op codes common with the ripple
// slices, and the sequencer state encoding.
package alu_defs;

    localparam logic [1:0] SOP_AND = 2'd0;
    localparam logic [1:0] SOP_OR  = 2'd1;
    localparam logic [1:0] SOP_ADD = 2'd2;
    localparam logic [1:0] SOP_SLT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_bit.sv
// One-bit ALU slice used by the serial sequencer. Purely combinational;
// set and ovf are only meaningful on the MSB and are forced low elsewhere.
module alu_serial_bit
    import alu_defs::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       binvert,
    input  logic [1:0] op,
    input  logic       is_msb,
    output logic       res,
    output logic       cout,
    output logic       set,
    output logic       ovf
);

    logic b2;
    logic sum;

    // Full-adder with optional b inversion, op mux, and MSB-only set/overflow.
    always_comb begin
        b2   = binvert ? ~b : b;
        sum  = a ^ b2 ^ cin;
        cout = (a & b2) | (a & cin) | (b2 & cin);
        case (op)
            SOP_AND: res = a & b;
            SOP_OR:  res = a | b;
            SOP_ADD: res = sum;
            default: res = 1'b0;
        endcase
        // When the operand signs differ the sum cannot overflow, so its sign is
        // trustworthy; when they match, the true sign is the shared sign of a.
        set = is_msb & ((a != b2) ? sum : a);
        ovf = is_msb & (op == SOP_ADD) & (a == b2) & (sum != a);
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one WIDTH-bit operation through a single
// one-bit slice, LSB first, carry held in a flop between cycles.
module alu_serial_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             binvert,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;   // low bits gathered so far; MSB arrives last
    logic [WIDTH-1:0] res_nxt;
    logic [1:0]       op_q;
    logic             binv_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic             bit_res, bit_cout, bit_set, bit_ovf;

    assign last    = (cnt == CW'(WIDTH - 1));
    assign accept  = start & ((state == IDLE) | (state == DONE));
    assign res_nxt = {bit_res, res_sr};
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    alu_serial_bit u_bit (
        .a       (a_sr[0]),
        .b       (b_sr[0]),
        .cin     (carry),
        .binvert (binv_q),
        .op      (op_q),
        .is_msb  (last),
        .res     (bit_res),
        .cout    (bit_cout),
        .set     (bit_set),
        .ovf     (bit_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state: start is only honoured in IDLE/DONE, never mid-run.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shifting, and completion update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            op_q     <= SOP_AND;
            binv_q   <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            op_q   <= op;
            binv_q <= binvert;
            carry  <= binvert;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt[WIDTH-1:1];
            carry  <= bit_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                result   <= (op_q == SOP_SLT) ? {{(WIDTH-1){1'b0}}, bit_set} : res_nxt;
                overflow <= bit_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed + randomized bench for alu_serial_seq (WIDTH = 8).
module tb_alu_serial_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic         binvert = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, overflow;
    logic [W-1:0] result;

    int vectors = 0;
    int fails = 0;
    logic [W-1:0] last_res = '0;
    logic         last_ovf = 1'b0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .binvert(binvert),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic on signed integers, not bit slices.
    function automatic logic [W:0] model(input logic [1:0] o, input logic bi,
                                         input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] y2, r;
        logic         v;
        int           s;
        y2 = bi ? ~y : y;
        s  = int'($signed(x)) + int'($signed(y2)) + int'(bi);
        r  = '0;
        v  = 1'b0;
        case (o)
            2'd0: r = x & y;
            2'd1: r = x | y;
            2'd2: begin r = W'(s); v = (s > 127) || (s < -128); end
            default: r = (s < 0) ? 8'd1 : 8'd0;
        endcase
        return {v, r};
    endfunction

    task automatic start_op(input logic [1:0] o, input logic bi, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; binvert = bi; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for completion, checking timing, held outputs, and the pulse.
    // intrude>0 pulses a stray start at that RUN cycle; chain launches the
    // next op (nop..nb) with start held through DONE.
    task automatic finish_op(input string tag, input logic [W-1:0] er, input logic eo,
                             input int intrude, input logic chain,
                             input logic [1:0] nop, input logic nbi,
                             input logic [W-1:0] na, input logic [W-1:0] nbv);
        int   nbusy = 0;
        int   cyc = 0;
        logic seen = 1'b0;
        logic both = 1'b0;
        if (start) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy && done) both = 1'b1;
            if (done) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                chk({tag, " held_res"}, result, last_res);
                chk({tag, " held_ovf"}, overflow, last_ovf);
            end
            if (intrude > 0 && cyc == intrude) begin
                op = 2'($urandom); binvert = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
                start = 1'b1;
            end
            if (intrude > 0 && cyc == intrude + 1) start = 1'b0;
        end
        chk({tag, " done_seen"}, seen, 1);
        chk({tag, " done_cycle"}, cyc, W + 1);
        chk({tag, " busy_cycles"}, nbusy, W);
        chk({tag, " busy_and_done"}, both, 0);
        chk({tag, " result"}, result, er);
        chk({tag, " overflow"}, overflow, eo);
        last_res = er;
        last_ovf = eo;
        if (chain) begin
            op = nop; binvert = nbi; a = na; b = nbv; start = 1'b1;
        end else begin
            @(negedge clk);
            chk({tag, " done_pulse_end"}, done, 0);
            chk({tag, " idle_busy"}, busy, 0);
        end
    endtask

    initial begin
        logic [W:0] m;
        logic [1:0] ro;
        logic       rb;
        logic [W-1:0] ra, rbv;

        // Reset state
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with overflow
        start_op(2'd2, 1'b0, 8'h7F, 8'h01);
        finish_op("add_ovf", 8'h80, 1'b1, 0, 1'b0, 0, 0, 0, 0);
        // Subtracts
        start_op(2'd2, 1'b1, 8'h05, 8'h07);
        finish_op("sub_neg", 8'hFE, 1'b0, 0, 1'b0, 0, 0, 0, 0);
        start_op(2'd2, 1'b1, 8'h80, 8'h01);
        finish_op("sub_ovf", 8'h7F, 1'b1, 0, 1'b0, 0, 0, 0, 0);
        // SLT
        start_op(2'd3, 1'b1, 8'h80, 8'h01);
        finish_op("slt_ovf", 8'h01, 1'b0, 0, 1'b0, 0, 0, 0, 0);
        start_op(2'd3, 1'b1, 8'h01, 8'h80);
        finish_op("slt_gt", 8'h00, 1'b0, 0, 1'b0, 0, 0, 0, 0);
        start_op(2'd3, 1'b1, 8'h03, 8'h03);
        finish_op("slt_eq", 8'h00, 1'b0, 0, 1'b0, 0, 0, 0, 0);
        // Logic ops ignore binvert
        start_op(2'd0, 1'b1, 8'hC3, 8'h5A);
        finish_op("and", 8'h42, 1'b0, 0, 1'b0, 0, 0, 0, 0);
        start_op(2'd1, 1'b1, 8'hC3, 8'h5A);
        finish_op("or", 8'hDB, 1'b0, 0, 1'b0, 0, 0, 0, 0);

        // Stray start mid-run is ignored
        start_op(2'd2, 1'b0, 8'h12, 8'h34);
        finish_op("intrude", 8'h46, 1'b0, 3, 1'b0, 0, 0, 0, 0);
        // Back-to-back chain: OR -> SLT -> ADD
        start_op(2'd1, 1'b0, 8'h0F, 8'hF0);
        finish_op("b2b_1", 8'hFF, 1'b0, 0, 1'b1, 2'd3, 1'b1, 8'hFF, 8'h01);
        finish_op("b2b_2", 8'h01, 1'b0, 0, 1'b1, 2'd2, 1'b0, 8'h80, 8'h80);
        finish_op("b2b_3", 8'h00, 1'b1, 0, 1'b0, 0, 0, 0, 0);

        // Reset in the middle of a run
        start_op(2'd2, 1'b0, 8'h55, 8'h11);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
        chk("midrst overflow", overflow, 0);
        last_res = '0;
        last_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst done", done, 0);
            chk("postrst busy", busy, 0);
        end
        start_op(2'd2, 1'b0, 8'h10, 8'h20);
        finish_op("postrst_add", 8'h30, 1'b0, 0, 1'b0, 0, 0, 0, 0);

        // Randomized against the reference model
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            rb = 1'($urandom);
            ra = 8'($urandom);
            rbv = 8'($urandom);
            m = model(ro, rb, ra, rbv);
            start_op(ro, rb, ra, rbv);
            finish_op("rand", m[W-1:0], m[W], 0, 1'b0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial ALU sequencer. It computes one WIDTH-bit ALU operation by pushing the operands through a single one-bit slice, LSB first, one bit per clock, and carrying the carry between cycles in a flop. It supports the same four ops and the same `binvert` convention as the ripple ALU slices, so it returns identical results, overflow and set-less-than values. It replaces the WIDTH-slice ripple datapath where area matters more than latency, and presents a start/busy/done handshake to the controller.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  0 = AND, 1 = OR, 2 = ADD, 3 = SLT; captured with `start`.
- binvert  in  1  invert b for ADD/SLT, and initial carry-in; captured with `start`.
- a  in  WIDTH  operand A; captured with `start`.
- b  in  WIDTH  operand B; captured with `start`.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when `result` and `overflow` are updated.
- result  out  WIDTH  registered result; held until the next completion.
- overflow  out  1  signed overflow of ADD; 0 for every other op.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE + start → RUN.
  - RUN with bit counter = WIDTH-1 → DONE.
  - DONE + start → RUN.
  - DONE without start → IDLE.
- Capture: on the accepting edge, load the a and b shift registers and latch op and binvert. Set carry = binvert and bit counter = 0.
- Each RUN edge processes bit i = counter from the shift-register LSBs:
  - b2 = binvert ? ~b_i : b_i.
  - sum = a_i ^ b2 ^ carry.
  - Bit result: AND → a_i & b_i; OR → a_i | b_i (binvert ignored for both); ADD → sum; SLT → 0.
  - The bit result shifts into the result shift register from the MSB side.
  - carry ← majority(a_i, b2, carry).
  - Counter increments.
- MSB cycle (counter = WIDTH-1) also computes:
  - set = (a_i != b2) ? sum : a_i, i.e. the correct sign of a−b even when the subtraction overflows.
  - ovf = (op == ADD) & (a_i == b2) & (sum != a_i).
- Completion at the edge entering DONE:
  - result ← assembled word; for SLT, result ← {WIDTH-1 zeros, set}.
  - overflow ← ovf.
  - done = 1 for exactly the DONE cycle.
- start in RUN is ignored; there is no queueing.
- result and overflow change only at completion.
- Reset (asynchronous, any time, including mid-RUN):
  - state = IDLE; busy = 0, done = 0, result = 0, overflow = 0.
  - Carry, counter and shift registers clear.
  - A partial operation is discarded; the next start after deassertion operates normally.

## Timing
- Start accepted at edge E0.
- busy = 1 for the WIDTH cycles following E0.
- result, overflow and done update at edge E0+WIDTH; done is high during the cycle after it.
- Latency from start edge to done: WIDTH+1 edges to observed done. Throughput: one operation per WIDTH+1 cycles.
- Back-to-back: start held high during DONE is accepted at the edge leaving DONE. done still pulses for one cycle, and busy rises the next cycle.
- busy and done are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package / include `alu_defs`:
  - op encodings SOP_AND = 0, SOP_OR = 1, SOP_ADD = 2, SOP_SLT = 3 (common with the ripple slices);
  - state encodings IDLE, RUN, DONE.
- Sub-module `alu_serial_bit`: combinational one-bit slice.
  - Inputs: a, b, cin, binvert, op, is_msb.
  - Outputs: bit result, cout, set, ovf.
- Sequencer, counter (clog2(WIDTH) bits), shift registers and output registers live in `alu_serial_seq`.

## Test plan
All scenarios use WIDTH = 8.
1. ADD a = 0x7F, b = 0x01, binvert = 0 → result 0x80, overflow = 1, done observed 9 edges after the start edge, busy high 8 cycles.
2. ADD a = 0x05, b = 0x07, binvert = 1 → result 0xFE, overflow = 0. Then a = 0x80, b = 0x01, binvert = 1 → result 0x7F, overflow = 1.
3. SLT with binvert = 1:
   - a = 0x80, b = 0x01 → result 0x01, overflow = 0 (set is correct despite the subtract overflow);
   - a = 0x01, b = 0x80 → result 0x00;
   - a = 0x03, b = 0x03 → result 0x00.
4. AND a = 0xC3, b = 0x5A, binvert = 1 → result 0x42 (binvert ignored). OR on the same operands → 0xDB. overflow = 0 for both.
5. Handshake: start pulsed at RUN cycle 3 with different operands → ignored, and the original result completes. start held through DONE → second operation runs immediately, with exactly one done pulse per operation.
6. Reset: rst_n low at RUN cycle 4 → busy, done, result and overflow go to 0 immediately, with no done pulse. After release, ADD 0x10 + 0x20 → 0x30.
